// File: rtl/snn_pkg.sv
// Shared constants and types for the SNN input loader slice.
//
// Contents:
//   NUM_PIXELS     - pixels per binary input image (784 = 28x28)
//   PIX_ADDR_W     - width of a pixel address
//   BITS_PER_BYTE  - pixels carried by one UART byte
//   loader_state_t - encoding of the loader control states
//   is_read_phase  - true in the states where the core owns the RAM port
package snn_pkg;

  localparam int NUM_PIXELS    = 784;
  localparam int PIX_ADDR_W    = 10;
  localparam int BITS_PER_BYTE = 8;

  typedef enum logic [2:0] {
    LD_IDLE      = 3'd0,
    LD_UNPACK    = 3'd1,
    LD_WAIT_BYTE = 3'd2,
    LD_START     = 3'd3,
    LD_RUN       = 3'd4
  } loader_state_t;

  function automatic logic is_read_phase(input logic [2:0] st);
    return (st == LD_START) || (st == LD_RUN);
  endfunction

endpackage

// File: rtl/snn_input_loader_if.sv
// Bus bundle between the input loader, the UART receiver and the network core.
//
// Signals:
//   rx_rdy          UART byte available (level, held until acknowledged)
//   rx_data[7:0]    UART received byte
//   rx_clr_rdy      one-cycle acknowledge back to the UART
//   addr_input_unit pixel read address from the core
//   q_input         pixel value, one cycle after the address
//   start           one-cycle pulse: image complete
//   core_done       core finished classification
//   busy            loader holds an image (loading or in use)
//   load_err        sticky mid-image timeout flag (0 unless the timeout build)
//
// Modports:
//   master - the environment side (UART + core)
//   slave  - the loader itself
interface snn_input_loader_if
  import snn_pkg::*;
#(
  parameter int ADDR_W = PIX_ADDR_W
);

  logic              rx_rdy;
  logic [7:0]        rx_data;
  logic              rx_clr_rdy;
  logic [ADDR_W-1:0] addr_input_unit;
  logic              q_input;
  logic              start;
  logic              core_done;
  logic              busy;
  logic              load_err;

  modport master (
    output rx_rdy, rx_data, addr_input_unit, core_done,
    input  rx_clr_rdy, q_input, start, busy, load_err
  );

  modport slave (
    input  rx_rdy, rx_data, addr_input_unit, core_done,
    output rx_clr_rdy, q_input, start, busy, load_err
  );

endinterface

// File: rtl/snn_input_loader_ram.sv
// input_bit_ram: single-port DEPTH x 1 synchronous RAM holding the unpacked
// input image. The read data is registered (one-cycle latency); a read of the
// address being written returns the old contents. Addresses at or beyond
// DEPTH read as 0 and ignore writes.
//
// Ports:
//   clk  - clock
//   data - write data bit
//   addr - read/write address
//   we   - write enable
//   q    - registered read data
module input_bit_ram
  import snn_pkg::*;
#(
  parameter int DEPTH  = NUM_PIXELS,
  parameter int ADDR_W = PIX_ADDR_W
) (
  input  logic              clk,
  input  logic              data,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  output logic              q
);

  logic mem [0:DEPTH-1];
  logic in_range;

  assign in_range = (int'(addr) < DEPTH);

  always_ff @(posedge clk) begin
    if (we && in_range) begin
      mem[addr] <= data;
    end
    q <= in_range ? mem[addr] : 1'b0;
  end

endmodule

// File: rtl/snn_input_loader.sv
// snn_input_loader: upstream feeder for the SNN core.
//
// Receives a NUM_PIXELS-pixel binary image from the UART as NUM_PIXELS/8
// bytes, unpacks each byte LSB first into a NUM_PIXELS x 1 RAM (byte k, bit b
// lands at pixel 8k+b), pulses start, then serves the core's 1-bit pixel
// reads until core_done re-arms it. Bytes that arrive while the core runs are
// left unacknowledged in the UART for the next image.
//
// Ports:
//   clk   - system clock, all flops on its rising edge
//   rst_n - synchronous active-low reset
//   bus   - snn_input_loader_if.slave (UART handshake, core read port,
//           start/core_done/busy/load_err)
//
// Optional build macro SNN_LOADER_TIMEOUT_EN: a gap counter aborts a load
// that idles TIMEOUT_CYCLES cycles between bytes, returning to IDLE with the
// sticky load_err flag set. Without it the loader waits indefinitely and
// load_err is tied low.
module snn_input_loader
  import snn_pkg::*;
#(
  parameter int NUM_PIXELS     = snn_pkg::NUM_PIXELS,
  parameter int ADDR_W         = PIX_ADDR_W,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input logic              clk,
  input logic              rst_n,
  snn_input_loader_if.slave bus
);

  localparam logic [2:0] ST_IDLE      = LD_IDLE;
  localparam logic [2:0] ST_UNPACK    = LD_UNPACK;
  localparam logic [2:0] ST_WAIT_BYTE = LD_WAIT_BYTE;
  localparam logic [2:0] ST_START     = LD_START;
  localparam logic [2:0] ST_RUN       = LD_RUN;

  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(NUM_PIXELS - 1);

  // Reject configurations the unpacker cannot serve.
  if ((NUM_PIXELS % BITS_PER_BYTE) != 0 || NUM_PIXELS > (1 << ADDR_W) ||
      TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("snn_input_loader: invalid NUM_PIXELS/ADDR_W/TIMEOUT_CYCLES");
  end

  logic [2:0]        state;
  logic [7:0]        shift_p0;
  logic [2:0]        bit_cnt;
  logic [ADDR_W-1:0] pix_cnt;
  logic              rx_clr_q;
  logic              busy_q;
  logic              rd_vld_p1;
  logic              read_phase;
  logic              timeout_hit;

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic              ram_q;

  assign read_phase = is_read_phase(state);

  // The loader owns the RAM port while filling; the core owns it from START.
  assign ram_addr = read_phase ? bus.addr_input_unit : pix_cnt;
  assign ram_we   = (state == ST_UNPACK);

  input_bit_ram #(
    .DEPTH  (NUM_PIXELS),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk  (clk),
    .data (shift_p0[0]),
    .addr (ram_addr),
    .we   (ram_we),
    .q    (ram_q)
  );

  // ---- control FSM / byte unpacker ------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      shift_p0  <= '0;
      bit_cnt   <= '0;
      pix_cnt   <= '0;
      rx_clr_q  <= 1'b0;
      busy_q    <= 1'b0;
      rd_vld_p1 <= 1'b0;
    end else begin
      rx_clr_q  <= 1'b0;
      rd_vld_p1 <= read_phase;
      case (state)
        ST_IDLE: begin
          if (bus.rx_rdy) begin
            shift_p0 <= bus.rx_data;
            rx_clr_q <= 1'b1;
            busy_q   <= 1'b1;
            pix_cnt  <= '0;
            bit_cnt  <= '0;
            state    <= ST_UNPACK;
          end
        end
        ST_UNPACK: begin
          shift_p0 <= shift_p0 >> 1;
          pix_cnt  <= pix_cnt + 1'b1;
          bit_cnt  <= bit_cnt + 3'd1;
          // bit_cnt wraps to 0 by itself after the eighth bit.
          if (bit_cnt == 3'd7) begin
            state <= (pix_cnt == LAST_PIX) ? ST_START : ST_WAIT_BYTE;
          end
        end
        ST_WAIT_BYTE: begin
          if (bus.rx_rdy) begin
            shift_p0 <= bus.rx_data;
            rx_clr_q <= 1'b1;
            state    <= ST_UNPACK;
          end else if (timeout_hit) begin
            busy_q <= 1'b0;
            state  <= ST_IDLE;
          end
        end
        ST_START: begin
          state <= ST_RUN;
        end
        ST_RUN: begin
          if (bus.core_done) begin
            busy_q <= 1'b0;
            state  <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // ---- mid-image gap watchdog -----------------------------------------------
`ifdef SNN_LOADER_TIMEOUT_EN
  localparam int GAP_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [GAP_W-1:0] gap_cnt;
  logic             load_err_q;

  // gap_cnt holds the number of earlier idle cycles, so the abort lands on
  // the TIMEOUT_CYCLES-th cycle spent waiting.
  assign timeout_hit = (state == ST_WAIT_BYTE) && !bus.rx_rdy &&
                       (gap_cnt == GAP_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gap_cnt    <= '0;
      load_err_q <= 1'b0;
    end else begin
      if ((state == ST_WAIT_BYTE) && !bus.rx_rdy) begin
        gap_cnt <= gap_cnt + 1'b1;
      end else begin
        gap_cnt <= '0;
      end
      if (timeout_hit) begin
        load_err_q <= 1'b1;
      end else if ((state == ST_IDLE) && bus.rx_rdy) begin
        load_err_q <= 1'b0;
      end
    end
  end

  assign bus.load_err = load_err_q;
`else
  assign timeout_hit  = 1'b0;
  assign bus.load_err = 1'b0;
`endif

  // ---- outputs --------------------------------------------------------------
  assign bus.rx_clr_rdy = rx_clr_q;
  assign bus.busy       = busy_q;
  assign bus.start      = (state == ST_START);
  // RAM data is only meaningful for addresses the core issued while it owned
  // the port, and the pixel output stays low outside START/RUN.
  assign bus.q_input    = ram_q & rd_vld_p1 & read_phase;

endmodule

// File: tb/tb_snn_input_loader.sv
module tb_snn_input_loader;
  import snn_pkg::*;

  localparam int NPIX   = 784;
  localparam int NBYTES = NPIX / 8;

  typedef struct {
    int   addr;
    logic exp;
  } rd_vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  snn_input_loader_if #(.ADDR_W(10)) bus ();

  snn_input_loader #(
    .NUM_PIXELS     (NPIX),
    .ADDR_W         (10),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  int cyc       = 0;
  int ack_cnt   = 0;
  int start_cnt = 0;
  int start_cyc = 0;

  logic [7:0] img [NBYTES];
  rd_vec_t    vecs [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.rx_clr_rdy) ack_cnt <= ack_cnt + 1;
    if (bus.start) begin
      start_cnt <= start_cnt + 1;
      start_cyc <= cyc;
    end
  end

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // UART model: present a byte, wait (bounded) for the acknowledge, drop rx_rdy.
  task automatic send_byte(input logic [7:0] b);
    bit got;
    got = 1'b0;
    bus.rx_data = b;
    bus.rx_rdy  = 1'b1;
    for (int i = 0; i < 40 && !got; i++) begin
      tick();
      if (bus.rx_clr_rdy) got = 1'b1;
    end
    bus.rx_rdy = 1'b0;
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL ack_timeout: byte %0h got no ack, required ack within 40 cycles", b);
    end
  endtask

  task automatic send_range(input int from, input int to);
    for (int k = from; k <= to; k++) send_byte(img[k]);
  endtask

  task automatic wait_start(input string name, input int st0);
    int n;
    n = 0;
    while (start_cnt == st0 && n < 30) begin
      tick();
      n++;
    end
    check_eq(name, start_cnt - st0, 1);
  endtask

  task automatic read_pix(input string name, input int a, input logic exp);
    bus.addr_input_unit = 10'(a);
    tick();
    check_eq($sformatf("%s_addr%0d", name, a), {31'd0, bus.q_input}, {31'd0, exp});
  endtask

  task automatic apply_vecs(input string name);
    foreach (vecs[i]) read_pix(name, vecs[i].addr, vecs[i].exp);
  endtask

  task automatic pulse_core_done();
    bus.core_done = 1'b1;
    tick();
    bus.core_done = 1'b0;
  endtask

  initial begin
    int ack0, st0, first_cyc, ones_bad;
    bit got;

    bus.rx_rdy = 1'b0;
    bus.rx_data = 8'h00;
    bus.addr_input_unit = '0;
    bus.core_done = 1'b0;
    rst_n = 1'b0;
    repeat (3) tick();

    check_eq("rst_busy",     {31'd0, bus.busy},       0);
    check_eq("rst_start",    {31'd0, bus.start},      0);
    check_eq("rst_clr_rdy",  {31'd0, bus.rx_clr_rdy}, 0);
    check_eq("rst_q_input",  {31'd0, bus.q_input},    0);
    check_eq("rst_load_err", {31'd0, bus.load_err},   0);
    rst_n = 1'b1;
    tick();

    // ---- all-ones image, back-to-back ----
    for (int k = 0; k < NBYTES; k++) img[k] = 8'hFF;
    ack0 = ack_cnt;
    st0  = start_cnt;
    send_byte(img[0]);
    first_cyc = cyc;
    check_eq("t1_busy_after_first", {31'd0, bus.busy}, 1);
    send_range(1, NBYTES - 1);
    wait_start("t1_start", st0);
    check_eq("t1_acks", ack_cnt - ack0, NBYTES);
    check_eq("t1_latency", start_cyc - first_cyc, NBYTES * 9 - 1);
    check_eq("t1_busy_run", {31'd0, bus.busy}, 1);
    ones_bad = 0;
    for (int a = 0; a < NPIX; a++) read_pix("t1_rd", a, 1'b1);
    check_eq("t1_single_start", start_cnt - st0, 1);
    pulse_core_done();
    check_eq("t1_busy_done", {31'd0, bus.busy}, 0);
    check_eq("t1_q_idle",    {31'd0, bus.q_input}, 0);

    // ---- sparse image 0x01, 0x80, zeros ----
    for (int k = 0; k < NBYTES; k++) img[k] = 8'h00;
    img[0] = 8'h01;
    img[1] = 8'h80;
    st0 = start_cnt;
    send_range(0, NBYTES - 1);
    wait_start("t2_start", st0);
    vecs = '{'{0, 1'b1}, '{15, 1'b1}, '{1, 1'b0}, '{8, 1'b0},
             '{14, 1'b0}, '{7, 1'b0}, '{16, 1'b0}, '{783, 1'b0}};
    apply_vecs("t2_rd");

    // ---- byte offered during RUN waits for core_done ----
    ack0 = ack_cnt;
    bus.rx_data = 8'hA5;
    bus.rx_rdy  = 1'b1;
    repeat (20) tick();
    check_eq("t3_no_ack_in_run", ack_cnt - ack0, 0);
    read_pix("t3_rd_still", 15, 1'b1);
    pulse_core_done();
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      if (bus.rx_clr_rdy) got = 1'b1;
      else tick();
    end
    bus.rx_rdy = 1'b0;
    check_eq("t3_ack_after_done", {31'd0, got}, 1);
    check_eq("t3_busy", {31'd0, bus.busy}, 1);
    for (int k = 0; k < NBYTES; k++) img[k] = 8'h00;
    st0 = start_cnt;
    send_range(1, NBYTES - 1);
    wait_start("t3_start", st0);
    vecs = '{'{0, 1'b1}, '{1, 1'b0}, '{2, 1'b1}, '{3, 1'b0}, '{4, 1'b0},
             '{5, 1'b1}, '{6, 1'b0}, '{7, 1'b1}, '{8, 1'b0}, '{15, 1'b0}};
    apply_vecs("t3_rd");
    pulse_core_done();

    // ---- reset mid-load, core_done during WAIT_BYTE ----
    for (int k = 0; k < NBYTES; k++) img[k] = 8'hFF;
    send_range(0, 49);
    rst_n = 1'b0;
    repeat (2) tick();
    check_eq("t4_rst_busy",    {31'd0, bus.busy},       0);
    check_eq("t4_rst_clr_rdy", {31'd0, bus.rx_clr_rdy}, 0);
    rst_n = 1'b1;
    tick();
    for (int k = 0; k < NBYTES; k++) img[k] = 8'h00;
    img[0] = 8'h02;
    img[NBYTES - 1] = 8'h80;
    ack0 = ack_cnt;
    st0  = start_cnt;
    send_range(0, NBYTES - 2);
    repeat (15) tick();
    check_eq("t4_no_early_start", start_cnt - st0, 0);
    pulse_core_done();
    repeat (2) tick();
    check_eq("t5_busy_after_stray_done", {31'd0, bus.busy}, 1);
    check_eq("t5_no_start", start_cnt - st0, 0);
    send_byte(img[NBYTES - 1]);
    wait_start("t4_start", st0);
    check_eq("t4_acks", ack_cnt - ack0, NBYTES);
    vecs = '{'{0, 1'b0}, '{1, 1'b1}, '{2, 1'b0}, '{200, 1'b0},
             '{782, 1'b0}, '{783, 1'b1}};
    apply_vecs("t4_rd");
    pulse_core_done();

    // ---- stall mid-image ----
    for (int k = 0; k < NBYTES; k++) img[k] = 8'h33;
    send_range(0, 9);
    repeat (50) tick();
    check_eq("t6_busy_mid_stall", {31'd0, bus.busy}, 1);
    check_eq("t6_err_mid_stall",  {31'd0, bus.load_err}, 0);
    repeat (80) tick();
`ifdef SNN_LOADER_TIMEOUT_EN
    check_eq("t6_busy_timeout", {31'd0, bus.busy}, 0);
    check_eq("t6_err_timeout",  {31'd0, bus.load_err}, 1);
    send_byte(8'h01);
    check_eq("t6_err_cleared",  {31'd0, bus.load_err}, 0);
    check_eq("t6_busy_restart", {31'd0, bus.busy}, 1);
`else
    check_eq("t6_busy_no_timeout", {31'd0, bus.busy}, 1);
    check_eq("t6_err_tied",        {31'd0, bus.load_err}, 0);
    st0 = start_cnt;
    send_range(10, NBYTES - 1);
    wait_start("t6_start", st0);
    read_pix("t6_rd", 4, 1'b1);
`endif
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: simulation still running at 5 ms, required finish earlier");
    $fatal(1);
  end

endmodule
